imem_uart_loader: RTL
=====================

# imem_uart_loader

- Serial boot loader: the write-side counterpart to the instruction memory that the CPU fetch path only reads.
- Receives a framed program image over the board UART (`i_RXD1`) and writes 16-bit words into imem port B from address 0 upward.
- Holds the CPU in reset while loading, then releases it.
- Sits beside `imem2` in the top level, in the `clk_5` domain.

## Interface

Parameters:
- `CLKS_PER_BIT`, 521: clk cycles per UART bit (5 MHz / 9600 baud).
- `TIMEOUT_CLKS`, 5_000_000: max idle clocks between bytes inside a frame (1 s).
- `ADDR_W`, 16: imem address width.

Ports:
- `clk`, input, 1: system clock (`clk_5`).
- `reset`, input, 1: asynchronous, active-low reset.
- `rxd`, input, 1: UART line. Asynchronous to `clk`; idle high.
- `mem_we`, output, 1: one-cycle imem write strobe.
- `mem_addr`, output, ADDR_W: write address.
- `mem_din`, output, 16: write data.
- `cpu_hold`, output, 1: high while a load is in progress. ANDed into the CPU reset.
- `busy`, output, 1: high in any state other than WAIT_SYNC.
- `load_done`, output, 1: one-cycle pulse on a successful load.
- `load_err`, output, 1: sticky error flag. Cleared by the next sync byte or by reset.

## Operation

Frame format (all bytes 8N1, LSB first):
- Sync byte 0xA5.
- Word count N, high byte then low byte.
- 2N data bytes, each word high byte first.
- Checksum byte: 8-bit sum, mod 256, of the 2N data bytes.

Byte receiver:
- `rxd` passes through a 2-FF synchronizer.
- A falling edge in the idle state starts a wait of `CLKS_PER_BIT/2`, then the line is resampled.
- If the line is high at that resample, it is a false start: return to idle with no byte.
- Otherwise, sample 8 data bits at `CLKS_PER_BIT` spacing, then the stop bit.
- Stop bit = 1: pulse `rx_valid` with `rx_byte`.
- Stop bit = 0: pulse `rx_ferr` with no byte.

Loader FSM states: WAIT_SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM.

Transitions:
- WAIT_SYNC: any byte other than 0xA5 is ignored. On 0xA5: clear `load_err`, set `cpu_hold`, clear address and sum, go to LEN_HI.
- LEN_HI → LEN_LO → latch N.
  - N == 0: set `load_err`, go to WAIT_SYNC.
  - Otherwise go to DATA_HI.
- DATA_HI: store the high byte; go to DATA_LO.
- DATA_LO: complete the word and issue a write.
  - If `mem_addr` == N−1 at that write, go to CSUM.
  - Otherwise increment the address and go to DATA_HI.
- Every data byte is added into the 8-bit running sum, with wraparound.
- CSUM, byte equals sum: pulse `load_done`.
- CSUM, byte differs: set `load_err`.
- After CSUM, either outcome: drop `cpu_hold`, go to WAIT_SYNC.

Error handling:
- `rx_ferr` in any state except WAIT_SYNC: set `load_err`, drop `cpu_hold`, go to WAIT_SYNC.
- `rx_ferr` in WAIT_SYNC is ignored.
- Inter-byte counter: reset on each `rx_valid`, runs only when `busy`. When it reaches `TIMEOUT_CLKS`, apply the same error handling.
- N larger than 2^ADDR_W: the address wraps. The host must not send this; no check is made.
- Words already written before an error stay in imem; there is no rollback.

## Timing

- All outputs are 0 during and immediately after reset. FSM in WAIT_SYNC, receiver idle.
- Reset asserted mid-frame aborts immediately: no write, and `cpu_hold` drops asynchronously.
- `rx_valid` fires 1 clk after the stop-bit sample.
- `mem_we` is high for exactly 1 clk, the cycle after `rx_valid` for a DATA_LO byte. `mem_addr` and `mem_din` are stable during that cycle.
- `mem_addr` increments in the cycle after `mem_we`.
- `cpu_hold` rises the cycle after sync `rx_valid`.
- `load_done` / `load_err`: asserted, and `cpu_hold` falls, the cycle after CSUM `rx_valid`.
- Minimum byte spacing: 10 bit times. Back-to-back bytes with no idle gap must be received.

## Structure

Shared package `imem_loader_pkg`:
- FSM state enum.
- `SYNC_BYTE` = 8'hA5.
- Default `CLKS_PER_BIT` / `TIMEOUT_CLKS` constants.

Sub-module `uart_rx_byte`:
- Contains the synchronizer, bit timer, bit counter and shift register.
- Outputs `rx_byte`, `rx_valid`, `rx_ferr`.
- Reused later for a console receiver.

Top-level integration (outside this block): CPU reset = `reset & ~cpu_hold`.

## Test plan

- **Single-word load:** frame A5 00 01 12 34 46. Required: one write of addr 0 / data 0x1234, then `load_done` pulse, `load_err` = 0, `cpu_hold` low.
- **Multi-word load with sum wrap:** frame A5 00 03 FF FF 00 01 80 00, checksum 0x7F. Required: writes 0xFFFF, 0x0001, 0x8000 to addrs 0, 1, 2, then `load_done`.
- **Bad checksum:** same frame with checksum 0x7E. Required: all 3 writes occur, `load_err` = 1, no `load_done`. A following valid frame clears `load_err` on its sync byte.
- **Framing and false-start noise:**
  - Stop bit forced 0 on the LEN_LO byte: `load_err` = 1, return to WAIT_SYNC, no writes.
  - A 0.3-bit low glitch in idle: no byte received.
- **Timeout:** after A5 00 02 12, idle for `TIMEOUT_CLKS`+1. Required: `load_err` = 1, `cpu_hold` = 0. Bytes 0x55 and 0x00 sent afterwards are ignored.
- **Reset mid-frame and junk rejection:**
  - `reset` low during DATA_LO: no write, all outputs 0.
  - Leading bytes 0x00 0xFF before A5 are ignored.
  - N = 0 frame: `load_err` = 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART program-image loader.
package imem_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE        = 8'hA5;
  localparam int unsigned DEF_CLKS_PER_BIT = 521;        // 5 MHz / 9600 baud
  localparam int unsigned DEF_TIMEOUT_CLKS = 5_000_000;  // 1 s at 5 MHz

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    LEN_HI    = 3'd1,
    LEN_LO    = 3'd2,
    DATA_HI   = 3'd3,
    DATA_LO   = 3'd4,
    CSUM      = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // 8-bit running checksum, wraps mod 256
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, mid-bit sampling, false-start and framing checks.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int unsigned     CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rxd_m;
  logic             rxd_s;
  logic             rxd_prev;
  logic             fall;
  logic             tick;

  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_next;
  logic [7:0]       shreg;
  logic [7:0]       shreg_next;
  logic [7:0]       byte_next;
  logic             valid_next;
  logic             ferr_next;

  assign fall = rxd_prev & ~rxd_s;
  assign tick = (cnt == '0);

  // Two-flop synchronizer plus one delay stage for start-edge detection; line idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_m    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_m    <= rxd;
      rxd_s    <= rxd_m;
      rxd_prev <= rxd_s;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_next;
  end

  // Receiver next-state: a start bit still low at its midpoint commits to a full byte
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (tick) state_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && (bit_idx == 3'd7)) state_next = RX_STOP;
      RX_STOP:  if (tick) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Bit timer, bit counter, shift register and byte/error strobes
  always_comb begin
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shreg_next = shreg;
    byte_next  = rx_byte;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) cnt_next = HALF_LAST;
      end
      RX_START: begin
        if (tick) begin
          cnt_next = BIT_LAST;
          bit_next = 3'd0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (tick) begin
          shreg_next = {rxd_s, shreg[7:1]};
          cnt_next   = BIT_LAST;
          bit_next   = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rxd_s) begin
            valid_next = 1'b1;
            byte_next  = shreg;
          end else begin
            ferr_next = 1'b1;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: cnt_next = '0;
    endcase
  end

  // Receiver datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      bit_idx  <= bit_next;
      shreg    <= shreg_next;
      rx_byte  <= byte_next;
      rx_valid <= valid_next;
      rx_ferr  <= ferr_next;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Serial boot loader: parses a framed image from the UART and writes it into imem port B.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS);

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_ferr;

  loader_state_t     state;
  loader_state_t     state_next;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo;
  logic              abort;
  logic              last_word;
  logic [15:0]       n_len_lo;

  logic [15:0]       n_words;
  logic [15:0]       n_next;
  logic [7:0]        hi_byte;
  logic [7:0]        hi_next;
  logic [7:0]        sum;
  logic [7:0]        sum_next;
  logic              we_next;
  logic [ADDR_W-1:0] addr_next;
  logic [15:0]       din_next;
  logic              hold_next;
  logic              busy_next;
  logic              done_next;
  logic              err_next;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign tmo       = busy && (tmo_cnt == TMO_LAST);
  assign abort     = (state != WAIT_SYNC) && (rx_ferr || tmo);
  assign last_word = (mem_addr == ADDR_W'(n_words - 16'd1));
  assign n_len_lo  = {n_words[15:8], rx_byte};

  // Inter-byte idle counter, only meaningful inside a frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 tmo_cnt <= '0;
    else if (rx_valid || !busy) tmo_cnt <= '0;
    else if (!tmo)              tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Loader state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_SYNC;
    else        state <= state_next;
  end

  // Loader next-state: framing/timeout errors abort back to sync hunt
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = WAIT_SYNC;
    end else if (rx_valid) begin
      case (state)
        WAIT_SYNC: if (rx_byte == SYNC_BYTE) state_next = LEN_HI;
        LEN_HI:    state_next = LEN_LO;
        LEN_LO:    state_next = (n_len_lo == 16'd0) ? WAIT_SYNC : DATA_HI;
        DATA_HI:   state_next = DATA_LO;
        DATA_LO:   state_next = last_word ? CSUM : DATA_HI;
        CSUM:      state_next = WAIT_SYNC;
        default:   state_next = WAIT_SYNC;
      endcase
    end
  end

  // Loader outputs and datapath next values
  always_comb begin
    n_next    = n_words;
    hi_next   = hi_byte;
    sum_next  = sum;
    we_next   = 1'b0;
    addr_next = mem_addr;
    din_next  = mem_din;
    hold_next = cpu_hold;
    done_next = 1'b0;
    err_next  = load_err;
    busy_next = (state_next != WAIT_SYNC);

    // Address advances the cycle after a non-final write
    if (mem_we && (state == DATA_HI)) addr_next = mem_addr + ADDR_W'(1);

    if (abort) begin
      err_next  = 1'b1;
      hold_next = 1'b0;
    end else if (rx_valid) begin
      case (state)
        WAIT_SYNC: begin
          if (rx_byte == SYNC_BYTE) begin
            err_next  = 1'b0;
            hold_next = 1'b1;
            addr_next = '0;
            sum_next  = 8'h00;
          end
        end
        LEN_HI: n_next = {rx_byte, n_words[7:0]};
        LEN_LO: begin
          n_next = n_len_lo;
          if (n_len_lo == 16'd0) begin
            err_next  = 1'b1;
            hold_next = 1'b0;
          end
        end
        DATA_HI: begin
          hi_next  = rx_byte;
          sum_next = csum_add(sum, rx_byte);
        end
        DATA_LO: begin
          din_next = {hi_byte, rx_byte};
          we_next  = 1'b1;
          sum_next = csum_add(sum, rx_byte);
        end
        CSUM: begin
          if (rx_byte == sum) done_next = 1'b1;
          else                err_next  = 1'b1;
          hold_next = 1'b0;
        end
        default: hold_next = 1'b0;
      endcase
    end
  end

  // Registered loader outputs and frame bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_words   <= 16'd0;
      hi_byte   <= 8'h00;
      sum       <= 8'h00;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= 16'h0000;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      n_words   <= n_next;
      hi_byte   <= hi_next;
      sum       <= sum_next;
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_din   <= din_next;
      cpu_hold  <= hold_next;
      busy      <= busy_next;
      load_done <= done_next;
      load_err  <= err_next;
    end
  end

endmodule
